// File: rtl/gpio_pkg.sv
// gpio_pkg: shared types and defaults for the GPIO pulse generator.
// Optional continuous mode is selected with the GPIO_PULSE_CONT_EN macro.
package gpio_pkg;

  // Default width of the high/low width and pulse count fields.
  localparam int CNT_W_DEF = 16;

  // Pulse generator FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } pulse_state_t;

endpackage

// File: rtl/gpio_pulse_gen_if.sv
// gpio_pulse_gen_if: register-block <-> pulse generator signal bundle.
//
// Handshake: start and stop are single-cycle strobes with no ready/ack.
// start is accepted only when the generator is idle, stop is absent and
// (without GPIO_PULSE_CONT_EN) pulse_count is non-zero; otherwise it is
// dropped. stop aborts any running train and wins over a same-cycle start.
// busy reports an accepted train, done strobes once on normal completion.
// state is a debug view of the FSM.
interface gpio_pulse_gen_if
  import gpio_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);
  logic             start;
  logic             stop;
  logic [CNT_W-1:0] high_cycles;
  logic [CNT_W-1:0] low_cycles;
  logic [CNT_W-1:0] pulse_count;
  logic             pin_out;
  logic             busy;
  logic             done;
  pulse_state_t     state;

  modport master (
    output start, stop, high_cycles, low_cycles, pulse_count,
    input  pin_out, busy, done, state
  );

  modport slave (
    input  start, stop, high_cycles, low_cycles, pulse_count,
    output pin_out, busy, done, state
  );
endinterface

// File: rtl/gpio_down_counter.sv
// gpio_down_counter: loadable down-counter; last flags a count of 1.
// Decrement stops at 0 so an unloaded (zero) counter never reports last.
module gpio_down_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         last
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: load has priority over decrement.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last = (count_q == W'(1));

endmodule

// File: rtl/gpio_pulse_gen.sv
// gpio_pulse_gen: programmable GPIO pulse-train generator.
// Widths and count are latched at start; pin_out, busy and done are flops.
// Define GPIO_PULSE_CONT_EN to make pulse_count == 0 run until stop.
module gpio_pulse_gen
  import gpio_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  gpio_pulse_gen_if.slave   bus
);

  pulse_state_t     state_q, state_d;
  logic             pin_q, pin_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] high_w_q, high_w_d;
  logic [CNT_W-1:0] low_w_q, low_w_d;

  logic             ph_load, ph_en, ph_last;
  logic [CNT_W-1:0] ph_val;
  logic             pc_load, pc_en, pc_last;
  logic             start_ok;

  // A zero width is run as a single cycle.
  function automatic logic [CNT_W-1:0] nz(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

  // Length of the current high or low phase.
  gpio_down_counter #(.W(CNT_W)) u_phase_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (ph_load),
    .load_val (ph_val),
    .en       (ph_en),
    .last     (ph_last)
  );

  // Pulses remaining; stays at 0 (never last) in continuous mode.
  gpio_down_counter #(.W(CNT_W)) u_pulse_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (pc_load),
    .load_val (bus.pulse_count),
    .en       (pc_en),
    .last     (pc_last)
  );

  // Which start requests may open a train.
`ifdef GPIO_PULSE_CONT_EN
  assign start_ok = bus.start && !bus.stop;
`else
  assign start_ok = bus.start && !bus.stop && (bus.pulse_count != '0);
`endif

  // Next-state, counter control and next-output decode.
  always_comb begin
    state_d  = state_q;
    high_w_d = high_w_q;
    low_w_d  = low_w_q;
    done_d   = 1'b0;
    ph_load  = 1'b0;
    ph_val   = high_w_q;
    ph_en    = 1'b0;
    pc_load  = 1'b0;
    pc_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          high_w_d = nz(bus.high_cycles);
          low_w_d  = nz(bus.low_cycles);
          ph_load  = 1'b1;
          ph_val   = nz(bus.high_cycles);
          pc_load  = 1'b1;
          state_d  = HIGH;
        end
      end
      HIGH: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (ph_last) begin
          pc_en = 1'b1;
          if (pc_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            ph_load = 1'b1;
            ph_val  = low_w_q;
            state_d = LOW;
          end
        end else begin
          ph_en = 1'b1;
        end
      end
      LOW: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (ph_last) begin
          ph_load = 1'b1;
          ph_val  = high_w_q;
          state_d = HIGH;
        end else begin
          ph_en = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    pin_d  = (state_d == HIGH);
    busy_d = (state_d != IDLE);
  end

  // FSM state, latched widths and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pin_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      high_w_q <= '0;
      low_w_q  <= '0;
    end else begin
      state_q  <= state_d;
      pin_q    <= pin_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      high_w_q <= high_w_d;
      low_w_q  <= low_w_d;
    end
  end

  assign bus.pin_out = pin_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.state   = state_q;

endmodule

// File: tb/tb_gpio_pulse_gen.sv
// tb_gpio_pulse_gen: self-checking bench for gpio_pulse_gen.
// Honors GPIO_PULSE_CONT_EN the same way as the design.
module tb_gpio_pulse_gen;
  import gpio_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  // Expected {pin_out, busy, done} per cycle after a start.
  logic [2:0] exp_q[$];

  typedef struct {
    int h;
    int l;
    int n;
    int exp_busy;
    int exp_high;
  } vec_t;

  vec_t tbl[6];

  gpio_pulse_gen_if #(.CNT_W(W)) bus();

  gpio_pulse_gen #(.CNT_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [2:0] obs();
    return {bus.pin_out, bus.busy, bus.done};
  endfunction

  task automatic set_params(input int h, input int l, input int n);
    bus.high_cycles = W'(h);
    bus.low_cycles  = W'(l);
    bus.pulse_count = W'(n);
  endtask

  // Pulse start for one cycle (cycle 0); returns positioned in cycle 1.
  task automatic drive_start(input int h, input int l, input int n);
    set_params(h, l, n);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  // Reference waveform from the train rules: N high phases of max(H,1)
  // separated by low phases of max(L,1), then done, then idle.
  task automatic build_model(input int h, input int l, input int n);
    int hp;
    int lp;
    hp = (h == 0) ? 1 : h;
    lp = (l == 0) ? 1 : l;
    exp_q.delete();
    for (int p = 1; p <= n; p++) begin
      repeat (hp) exp_q.push_back(3'b110);
      if (p < n) repeat (lp) exp_q.push_back(3'b010);
    end
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b000);
  endtask

  // Run one train against the model. poke > 0 re-issues start with other
  // parameters in that cycle; scramble changes parameter inputs every cycle.
  task automatic run_model(input string name, input int h, input int l, input int n,
                           input int poke, input bit scramble);
    int cyc;
    build_model(h, l, n);
    drive_start(h, l, n);
    cyc = 1;
    while (exp_q.size() > 0) begin
      check(name, {29'd0, obs()}, {29'd0, exp_q.pop_front()});
      bus.start = (cyc == poke);
      if (scramble || cyc == poke)
        set_params($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(1, 9));
      step();
      cyc++;
    end
    bus.start = 1'b0;
    check({name, "_end_state"}, 32'(bus.state), 32'(IDLE));
  endtask

  initial begin
    logic [8:0] basic_pin;
    int busy_n, high_n, done_n, done_at;

    tbl[0] = '{3, 2, 2, 8, 6};
    tbl[1] = '{0, 0, 3, 5, 3};
    tbl[2] = '{1, 1, 1, 1, 1};
    tbl[3] = '{4, 0, 2, 9, 8};
    tbl[4] = '{0, 7, 1, 1, 1};
    tbl[5] = '{2, 3, 4, 17, 8};

    // Reset.
    rst = 1'b1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    set_params(0, 0, 0);
    #1;
    check("reset_outputs", {29'd0, obs()}, 32'd0);
    check("reset_state", 32'(bus.state), 32'(IDLE));
    step();
    step();
    rst = 1'b0;
    step();
    check("post_reset_idle", {29'd0, obs()}, 32'd0);

    // Basic train H=3 L=2 N=2, explicit waveform.
    basic_pin = 9'b011100111;
    drive_start(3, 2, 2);
    check("basic_busy_c1", 32'(bus.busy), 32'd1);
    for (int c = 1; c <= 9; c++) begin
      check($sformatf("basic_pin_c%0d", c), 32'(bus.pin_out), 32'(basic_pin[c-1]));
      if (c < 9) check($sformatf("basic_done_c%0d", c), 32'(bus.done), 32'd0);
      if (c < 9) step();
    end
    check("basic_done_c9", 32'(bus.done), 32'd1);
    check("basic_busy_c9", 32'(bus.busy), 32'd0);
    step();
    check("basic_done_c10", 32'(bus.done), 32'd0);

    // Table-driven trains: busy length, high cycles, done count/time.
    for (int i = 0; i < 6; i++) begin
      busy_n = 0; high_n = 0; done_n = 0; done_at = -1;
      drive_start(tbl[i].h, tbl[i].l, tbl[i].n);
      for (int c = 1; c <= 40; c++) begin
        if (bus.busy) busy_n++;
        if (bus.pin_out) high_n++;
        if (bus.done) begin done_n++; done_at = c; end
        step();
      end
      check($sformatf("tbl%0d_busy_len", i), 32'(busy_n), 32'(tbl[i].exp_busy));
      check($sformatf("tbl%0d_high_len", i), 32'(high_n), 32'(tbl[i].exp_high));
      check($sformatf("tbl%0d_done_cnt", i), 32'(done_n), 32'd1);
      check($sformatf("tbl%0d_done_at", i), 32'(done_at), 32'(tbl[i].exp_busy + 1));
    end

    // Abort: stop in cycle 4 of a long train, then a clean train.
    drive_start(10, 10, 5);
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("abort_pin_c%0d", c), 32'(bus.pin_out), 32'd1);
      bus.stop = (c == 4);
      step();
    end
    bus.stop = 1'b0;
    check("abort_pin_c5", {29'd0, obs()}, 32'd0);
    done_n = 0; busy_n = 0;
    for (int c = 0; c < 30; c++) begin
      if (bus.done) done_n++;
      if (bus.busy) busy_n++;
      step();
    end
    check("abort_no_done", 32'(done_n), 32'd0);
    check("abort_stays_idle", 32'(busy_n), 32'd0);
    run_model("after_abort", 2, 1, 2, 0, 1'b0);

    // start+stop together in IDLE: nothing happens.
    set_params(3, 3, 3);
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    step();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    busy_n = 0;
    for (int c = 0; c < 5; c++) begin
      if (bus.busy || bus.pin_out || bus.done) busy_n++;
      step();
    end
    check("start_stop_idle", 32'(busy_n), 32'd0);

    // start while busy with new parameters: waveform unchanged.
    run_model("start_while_busy", 3, 2, 3, 4, 1'b0);

    // Back-to-back: new start accepted in the done cycle.
    drive_start(1, 1, 1);
    step();
    check("b2b_done", {29'd0, obs()}, 32'b001);
    set_params(2, 1, 1);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("b2b_restart_c1", {29'd0, obs()}, 32'b110);
    step();
    check("b2b_restart_c2", {29'd0, obs()}, 32'b110);
    step();
    check("b2b_restart_done", {29'd0, obs()}, 32'b001);
    step();

`ifdef GPIO_PULSE_CONT_EN
    // Continuous mode: period-3 waveform until stop, never done.
    drive_start(2, 1, 0);
    done_n = 0; high_n = 0;
    for (int c = 1; c <= 120; c++) begin
      if (bus.pin_out !== (((c - 1) % 3) < 2)) high_n++;
      if (bus.done || !bus.busy) done_n++;
      bus.stop = (c == 120);
      step();
    end
    bus.stop = 1'b0;
    check("cont_waveform_errs", 32'(high_n), 32'd0);
    check("cont_no_done", 32'(done_n), 32'd0);
    check("cont_stopped", {29'd0, obs()}, 32'd0);
`else
    // pulse_count 0 is ignored.
    drive_start(2, 1, 0);
    busy_n = 0;
    for (int c = 0; c < 5; c++) begin
      if (bus.busy || bus.pin_out || bus.done) busy_n++;
      step();
    end
    check("zero_count_ignored", 32'(busy_n), 32'd0);
`endif

    // Asynchronous reset in the middle of a high phase.
    drive_start(5, 5, 2);
    step();
    #2 rst = 1'b1;
    #1;
    check("async_rst_outputs", {29'd0, obs()}, 32'd0);
    step();
    rst = 1'b0;
    check("async_rst_state", 32'(bus.state), 32'(IDLE));
    step();
    check("async_rst_still_idle", {29'd0, obs()}, 32'd0);
    run_model("after_reset", 1, 2, 2, 0, 1'b0);

    // Randomized trains against the model, with input scrambling and pokes.
    for (int i = 0; i < 30; i++) begin
      int h, l, n, b, poke;
      h = $urandom_range(0, 5);
      l = $urandom_range(0, 5);
      n = $urandom_range(1, 4);
      b = n * ((h == 0) ? 1 : h) + (n - 1) * ((l == 0) ? 1 : l);
      poke = ($urandom_range(0, 1) == 1) ? $urandom_range(1, b) : 0;
      run_model($sformatf("rand%0d", i), h, l, n, poke, 1'b1);
    end

    // Maximum width: one pulse of 2^W-1 cycles.
    drive_start((1 << W) - 1, 0, 1);
    high_n = 0; done_at = -1;
    for (int c = 1; c <= (1 << W) + 2; c++) begin
      if (bus.pin_out) high_n++;
      if (bus.done) done_at = c;
      step();
    end
    check("max_width_high", 32'(high_n), 32'((1 << W) - 1));
    check("max_width_done_at", 32'(done_at), 32'(1 << W));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
